// File: rtl/dump_pkg.sv
// dump_pkg: shared types and defaults for the dump-switch timing generator.
//   ST_IDLE/ST_DELAY/ST_ACTIVE : FSM state encoding (2 bits)
//   DUMP_DELAY_DEF/DUMP_PULSE_DEF : default delay and window lengths in clk_sys cycles
package dump_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2
    } dump_state_e;
    localparam int DUMP_DELAY_DEF = 16;
    localparam int DUMP_PULSE_DEF = 64;
endpackage

// File: rtl/rise_edge_det.sv
// rise_edge_det: single-flop rising-edge detector with configurable reset value.
//   clk   : clock
//   rst_n : synchronous active-low reset, history flop loads RST_VAL
//   sig   : synchronous input
//   rise  : combinational pulse, high when sig is 1 and was 0 on the previous edge
module rise_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);
    logic sig_q, sig_d;

    always_comb sig_d = sig;

    always_ff @(posedge clk) begin
        if (!rst_n) sig_q <= RST_VAL;
        else        sig_q <= sig_d;
    end

    assign rise = sig & ~sig_q;
endmodule

// File: rtl/dump_off_gen.sv
// dump_off_gen: delay-then-window timing generator for the Q-damping switch.
//   clk_sys     : system clock, all logic on the rising edge
//   rst_n       : synchronous active-low reset, aborts any running sequence
//   state_start : start request, only its rising edge starts a sequence
//   dump_off    : registered, high for PULSE_CYCLES cycles, DELAY_CYCLES after the start edge
module dump_off_gen
    import dump_pkg::*;
#(
    parameter int DELAY_CYCLES = DUMP_DELAY_DEF,
    parameter int PULSE_CYCLES = DUMP_PULSE_DEF,
    parameter int CNT_W        = 16
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic state_start,
    output logic dump_off
);
    localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

    generate
        if (PULSE_CYCLES == 0 || longint'(PULSE_CYCLES) > MAX_CNT ||
            DELAY_CYCLES < 0 || longint'(DELAY_CYCLES) > MAX_CNT) begin : g_param_err
            $error("dump_off_gen: DELAY_CYCLES/PULSE_CYCLES out of range for CNT_W");
        end
    endgenerate

    // Counters load N-1 so that the terminal zero cycle is part of the count.
    localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLS_LD = CNT_W'(PULSE_CYCLES - 1);

    dump_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dump_off_q, dump_off_d;
    logic             start_edge;

    // History flop resets to 1 so a request held high across reset release is ignored.
    rise_edge_det #(.RST_VAL(1'b1)) u_start_det (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .sig   (state_start),
        .rise  (start_edge)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dump_off_d = dump_off_q;
        case (state_q)
            ST_IDLE: begin
                dump_off_d = 1'b0;
                if (start_edge) begin
                    state_d    = (DELAY_CYCLES == 0) ? ST_ACTIVE : ST_DELAY;
                    cnt_d      = (DELAY_CYCLES == 0) ? PLS_LD : DLY_LD;
                    dump_off_d = (DELAY_CYCLES == 0);
                end
            end
            ST_DELAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d    = ST_ACTIVE;
                    cnt_d      = PLS_LD;
                    dump_off_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d    = ST_IDLE;
                    dump_off_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                dump_off_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dump_off_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dump_off_q <= dump_off_d;
        end
    end

    assign dump_off = dump_off_q;
endmodule

// File: tb/tb_dump_off_gen.sv
// tb_dump_off_gen: directed self-checking bench for dump_off_gen (default and DELAY=0/PULSE=1 builds).
`timescale 1ns/1ps
module tb_dump_off_gen;
    import dump_pkg::*;

    logic clk_sys = 1'b0;
    logic rst_n;
    logic start, start_c;
    logic dump_off, dump_c;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #50 clk_sys = ~clk_sys;

    dump_off_gen dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .state_start (start),
        .dump_off    (dump_off)
    );

    dump_off_gen #(.DELAY_CYCLES(0), .PULSE_CYCLES(1), .CNT_W(16)) dut_c (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .state_start (start_c),
        .dump_off    (dump_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Advance one rising edge, then sit on the falling edge for sampling and driving.
    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    // Starts a default-parameter sequence from the current falling edge; E0 is the next rising edge.
    task automatic run_window(input string tag, input bit retrig, input int last_k);
        int highs = 0;
        start = 1'b1;
        for (int k = 0; k <= last_k; k++) begin
            tick();
            check(tag, {31'd0, dump_off}, {31'd0, (k >= 16 && k <= 79)});
            highs += int'(dump_off);
            if (retrig && (k == 4 || k == 39)) start = 1'b0;
            if (retrig && (k == 5 || k == 40)) start = 1'b1;
        end
        check({tag, "_highs"}, highs, 64);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        start_c = 1'b0;
        @(negedge clk_sys);

        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_hold", {31'd0, dump_off}, 32'd0);
        end
        check("rst_hold_c", {31'd0, dump_c}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            check("idle", {31'd0, dump_off}, 32'd0);
        end

        run_window("basic", 1'b0, 100);
        start = 1'b0;
        tick();

        run_window("retrig", 1'b1, 150);
        start = 1'b0;
        tick();

        rst_n = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("held_hi", {31'd0, dump_off}, 32'd0);
        end
        start = 1'b0;
        tick();
        run_window("after_held", 1'b0, 90);
        start = 1'b0;
        tick();

        start = 1'b1;
        for (int k = 0; k <= 29; k++) begin
            tick();
            check("pre_abort", {31'd0, dump_off}, {31'd0, (k >= 16)});
        end
        rst_n = 1'b0;
        tick();
        check("abort_dump", {31'd0, dump_off}, 32'd0);
        check("abort_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("abort_idle", {31'd0, dump_off}, 32'd0);
        run_window("after_abort", 1'b0, 90);
        start = 1'b0;
        tick();

        start_c = 1'b1;
        tick();
        check("c_e0", {31'd0, dump_c}, 32'd1);
        start_c = 1'b0;
        tick();
        check("c_e1", {31'd0, dump_c}, 32'd0);
        start_c = 1'b1;
        tick();
        check("c_e2", {31'd0, dump_c}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("c_tail", {31'd0, dump_c}, 32'd0);
        end
        check("c_dflt_quiet", {31'd0, dump_off}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dump_off_gen.md
Name: dump_off_gen

Overview:
- Timing generator for the NMR front-end Q-damping ("dump") switch, clocked by the 10 MHz system clock.
- A rising edge on state_start, issued by the sequencer when a pulse-sequence state begins, starts a timed sequence.
- The sequence is a programmable delay followed by a programmable-width active-high dump_off window.
- Outside that window dump_off stays low, so the dump circuit stays engaged.

Parameters:
- DELAY_CYCLES, default 16: clk_sys cycles from the detected start edge to dump_off assertion. Legal range is 0 to 2^CNT_W-1.
- PULSE_CYCLES, default 64: clk_sys cycles dump_off stays high. Legal range is 1 to 2^CNT_W-1.
- CNT_W, default 16: width of the internal down-counter.

Ports:
- clk_sys, input, 1: system clock, 10 MHz nominal. All logic is on the rising edge.
- rst_n, input, 1: reset. Synchronous, active-low.
- state_start, input, 1: sequence-start request, synchronous to clk_sys. Only its rising edge is significant.
- dump_off, output, 1: registered, active-high. High means the dump circuit is switched off.

Behaviour:
- Reset (rst_n=0 sampled on a clock edge):
  - FSM goes to IDLE, counter=0, dump_off=0.
  - Edge-detect register start_d=1, so a state_start held high through reset release does not trigger.
  - Reset mid-sequence aborts immediately: dump_off is 0 after that edge.
- Edge detect:
  - start_d <= state_start every edge.
  - start_edge = state_start & ~start_d.
- FSM states: IDLE, DELAY, ACTIVE.
- IDLE:
  - dump_off=0.
  - On start_edge with DELAY_CYCLES>0: go to DELAY, counter<=DELAY_CYCLES-1.
  - On start_edge with DELAY_CYCLES=0: go to ACTIVE, counter<=PULSE_CYCLES-1, dump_off<=1.
- DELAY:
  - If counter!=0, decrement.
  - If counter==0: go to ACTIVE, dump_off<=1, counter<=PULSE_CYCLES-1.
- ACTIVE:
  - If counter!=0, decrement; dump_off stays 1.
  - If counter==0: go to IDLE, dump_off<=0.
- Timing: if E0 is the edge at which start_edge is sampled, dump_off is high after edge E0+DELAY_CYCLES and low after edge E0+DELAY_CYCLES+PULSE_CYCLES. That gives exactly PULSE_CYCLES high cycles.
- Retrigger:
  - start_edge in DELAY or ACTIVE is ignored; the running sequence is neither restarted nor extended.
  - state_start falling or toggling mid-sequence has no effect.
- Back-to-back:
  - Once back in IDLE, a start_edge sampled on the very next edge is accepted.
  - Because start_d runs continuously, an edge that occurred during a sequence is not queued.
- Glitch-free: dump_off is driven directly from a flop, never from combinational decode.
- Parameter check: elaboration-time error if PULSE_CYCLES==0 or if either count exceeds 2^CNT_W-1.

Decomposition:
- Shared package dump_pkg holds:
  - the FSM state enum (IDLE/DELAY/ACTIVE, 2-bit encoding);
  - default constants DUMP_DELAY_DEF=16 and DUMP_PULSE_DEF=64.
- One natural sub-module, rise_edge_det: single flop with configurable reset value plus AND gate, reused by other sequencer blocks.
- Counter and FSM stay in the top module.

Test Plan:
- Reset hold: rst_n=0 for 10 cycles with state_start=0, then release. dump_off=0 for 200 cycles with no stimulus.
- Basic sequence (defaults): state_start 0→1 sampled at edge E0, held high. dump_off low through E0+15, high from E0+16 through E0+79, low again from E0+80. High count is exactly 64.
- Retrigger ignored: pulse state_start 1→0→1 at E0+5 and again at E0+40. dump_off window unchanged (E0+16 to E0+79), with no second window.
- High through reset: state_start=1 while rst_n deasserts. No dump_off activity. A subsequent 0→1 triggers normally.
- Reset mid-ACTIVE: assert rst_n=0 at E0+30. dump_off=0 after that edge and FSM in IDLE. A new edge after release gives a full-length window.
- Corner parameters DELAY_CYCLES=0, PULSE_CYCLES=1: edge at E0 gives dump_off high for exactly the one cycle after E0. A back-to-back edge at E0+2 is accepted and gives another single-cycle pulse.
